// File: rtl/pool_window_gather.sv
`default_nettype none
// ============================================================================
// Module      : pool_window_gather
// Description : Gathers non-overlapping 2x2 windows from a row-major IL.FL
//               activation stream using a one-row line buffer and hands each
//               window to the pooling stage, paced by its idle indication.
//               Optional macro POOL_WINDOW_COUNT_EN adds the win_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_window_gather #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int SIZE  = 4,
    parameter int ROW_W = 4,
    parameter int ROW_H = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IL+FL-1:0]              din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [1:0]                    mode_in,
    input  logic                          pool_idle,
    output logic [SIZE-1:0][IL+FL-1:0]    im,
    output logic                          input_ready,
    output logic [1:0]                    mode,
    output logic                          frame_done
`ifdef POOL_WINDOW_COUNT_EN
    ,
    output logic [$clog2(ROW_W*ROW_H/4+1)-1:0] win_cnt
`endif
);

    localparam int c_dw = IL + FL;
    localparam int c_cw = $clog2(ROW_W);
    localparam int c_rw = $clog2(ROW_H);

    localparam logic [c_cw-1:0] c_col_last = c_cw'(ROW_W - 1);
    localparam logic [c_cw-1:0] c_col_one  = c_cw'(1);
    localparam logic [c_rw-1:0] c_row_last = c_rw'(ROW_H - 1);
    localparam logic [c_rw-1:0] c_row_one  = c_rw'(1);

    // Elaboration-time guards on the geometry this block supports.
    if (SIZE != 4) begin : g_bad_size
        $error("pool_window_gather: SIZE must be 4");
    end
    if ((ROW_W < 2) || (ROW_W % 2 != 0)) begin : g_bad_row_w
        $error("pool_window_gather: ROW_W must be even and >= 2");
    end
    if ((ROW_H < 2) || (ROW_H % 2 != 0)) begin : g_bad_row_h
        $error("pool_window_gather: ROW_H must be even and >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TOP  = 2'd1,
        S_BOT  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic                      r_rdy_en;
    logic                      r_pending;
    logic                      r_last;
    logic [1:0]                r_guard;
    logic [c_cw-1:0]           r_col;
    logic [c_rw-1:0]           r_row;
    logic [1:0]                r_mode;
    logic [SIZE-1:0][c_dw-1:0] r_im;
    logic [c_dw-1:0]           r_line_buf [ROW_W];
    logic [c_dw-1:0]           r_left;

    logic                      w_accept;
    logic                      w_issue;
    logic                      w_row_end;
    logic                      w_frame_end;

    // Input is refused whenever a window is waiting, whatever the state.
    assign din_ready   = r_rdy_en & ~r_pending;
    assign w_accept    = din_valid & din_ready;
    assign w_issue     = r_pending & pool_idle & (r_guard == 2'd0);
    assign w_row_end   = (r_col == c_col_last);
    assign w_frame_end = (r_row == c_row_last);

    assign input_ready = w_issue;
    assign frame_done  = w_issue & r_last;
    assign im          = r_im;
    assign mode        = r_mode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_TOP;
                end
            end
            S_TOP: begin
                if (w_accept && w_row_end) begin
                    w_state_nxt = S_BOT;
                end
            end
            S_BOT: begin
                if (w_accept && w_row_end) begin
                    w_state_nxt = w_frame_end ? S_IDLE : S_TOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdy_en  <= 1'b0;
            r_pending <= 1'b0;
            r_last    <= 1'b0;
            r_guard   <= 2'd0;
            r_col     <= '0;
            r_row     <= '0;
            r_mode    <= 2'd0;
            r_im      <= '0;
        end else begin
            r_rdy_en <= 1'b1;

            // The guard keeps a second issue away until pool_idle has had
            // time to reflect the pooling stage going busy.
            if (w_issue) begin
                r_pending <= 1'b0;
                r_guard   <= 2'd2;
            end else if (r_guard != 2'd0) begin
                r_guard <= r_guard - 2'd1;
            end

            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        r_mode <= mode_in;
                        r_col  <= c_col_one;
                        r_row  <= '0;
                    end
                    S_TOP: begin
                        if (w_row_end) begin
                            r_col <= '0;
                            r_row <= r_row + c_row_one;
                        end else begin
                            r_col <= r_col + c_col_one;
                        end
                    end
                    S_BOT: begin
                        if (r_col[0]) begin
                            r_im[0]   <= r_line_buf[r_col - c_col_one];
                            r_im[1]   <= r_line_buf[r_col];
                            r_im[2]   <= r_left;
                            r_im[3]   <= din;
                            r_pending <= 1'b1;
                            r_last    <= w_row_end & w_frame_end;
                        end
                        if (w_row_end) begin
                            r_col <= '0;
                            r_row <= w_frame_end ? '0 : (r_row + c_row_one);
                        end else begin
                            r_col <= r_col + c_col_one;
                        end
                    end
                    default: begin
                        r_col <= '0;
                        r_row <= '0;
                    end
                endcase
            end
        end
    end

    // Line buffer and left-pixel holder carry no reset; their contents are
    // always rewritten before they are read into a window.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (r_state == S_IDLE) begin
                r_line_buf[0] <= din;
            end else if (r_state == S_TOP) begin
                r_line_buf[r_col] <= din;
            end else if (!r_col[0]) begin
                r_left <= din;
            end
        end
    end

`ifdef POOL_WINDOW_COUNT_EN
    logic [$clog2(ROW_W*ROW_H/4+1)-1:0] r_win_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_cnt <= '0;
        end else if (w_accept && (r_state == S_IDLE)) begin
            r_win_cnt <= '0;
        end else if (w_issue) begin
            r_win_cnt <= r_win_cnt + 1'b1;
        end
    end

    assign win_cnt = r_win_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pool_window_gather.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pool_window_gather
// Description : Randomised self-checking bench for pool_window_gather with a
//               frame-level window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_window_gather;

    localparam int ROW_W = 4;
    localparam int ROW_H = 4;
    localparam int DW    = 20;
    localparam int NPIX  = ROW_W * ROW_H;

    typedef logic [3:0][DW-1:0] win_t;
    typedef struct {
        win_t       w;
        logic [1:0] m;
        logic       last;
    } exp_t;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic [DW-1:0] din       = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [1:0]    mode_in   = 2'd0;
    logic          pool_idle = 1'b1;
    win_t          im;
    logic          input_ready;
    logic [1:0]    mode;
    logic          frame_done;
`ifdef POOL_WINDOW_COUNT_EN
    logic [2:0]    win_cnt;
    int            exp_cnt = 0;
`endif

    int            n_vec   = 0;
    int            n_err   = 0;
    int            n_pulse = 0;
    int            n_fd    = 0;
    int            gap     = 100;
    int            pool_mode = 0;   // 0: always idle, 1: random, 2: held by main
    logic [DW-1:0] frame_px [NPIX];
    exp_t          exp_q [$];
    exp_t          mon_e;
    win_t          w1;

    pool_window_gather dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .mode_in     (mode_in),
        .pool_idle   (pool_idle),
        .im          (im),
        .input_ready (input_ready),
        .mode        (mode),
        .frame_done  (frame_done)
`ifdef POOL_WINDOW_COUNT_EN
        ,
        .win_cnt     (win_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: window (wr,wc) is the 2x2 block whose top-left pixel sits at
    // row 2*wr, column 2*wc of the row-major frame.
    task automatic push_frame(input logic [1:0] m);
        for (int wr = 0; wr < ROW_H/2; wr++) begin
            for (int wc = 0; wc < ROW_W/2; wc++) begin
                exp_t e;
                int   tl;
                tl     = 2*wr*ROW_W + 2*wc;
                e.w[0] = frame_px[tl];
                e.w[1] = frame_px[tl+1];
                e.w[2] = frame_px[tl+ROW_W];
                e.w[3] = frame_px[tl+ROW_W+1];
                e.m    = m;
                e.last = (wr == ROW_H/2-1) && (wc == ROW_W/2-1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill_seq(input int base);
        for (int i = 0; i < NPIX; i++) frame_px[i] = DW'(base + i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NPIX; i++) frame_px[i] = DW'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic send_frame(input int n_pix, input int vmode, input logic [1:0] m_first,
                              input logic [1:0] m_later, input int chg_after);
        int k   = 0;
        int cyc = 0;
        bit acc;
        mode_in = m_first;
        while (k < n_pix && cyc < 2000) begin
            din = frame_px[k];
            case (vmode)
                0:       din_valid = 1'b1;
                1:       din_valid = (cyc % 2 == 0);
                default: din_valid = ($urandom_range(0, 2) != 0);
            endcase
            @(negedge clk);
            acc = din_valid && din_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                if (k == 0) begin
                    push_frame(m_first);
`ifdef POOL_WINDOW_COUNT_EN
                    exp_cnt = 0;
`endif
                end
                k++;
                if (k == chg_after) mode_in = m_later;
            end
        end
        din_valid = 1'b0;
        check_val("send_complete", 128'(k), 128'(n_pix));
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_val("drain", 128'(exp_q.size()), 128'(0));
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (pool_mode == 1)      pool_idle = ($urandom_range(0, 3) != 0);
        else if (pool_mode == 0) pool_idle = 1'b1;
    end

    // Monitor: every issued window is matched in order against the model.
    always @(negedge clk) begin
        if (reset) begin
            gap++;
`ifdef POOL_WINDOW_COUNT_EN
            check_val("win_cnt", 128'(win_cnt), 128'(exp_cnt));
`endif
            if (input_ready) begin
                check_val("issue_pool_idle", 128'(pool_idle), 128'(1));
                check_val("issue_din_ready", 128'(din_ready), 128'(0));
                check_val("issue_spacing", 128'(gap >= 3), 128'(1));
                check_val("issue_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_val("im", 128'(im), 128'(mon_e.w));
                    check_val("mode", 128'(mode), 128'(mon_e.m));
                    check_val("frame_done", 128'(frame_done), 128'(mon_e.last));
                end
                gap = 0;
                n_pulse++;
                if (frame_done) n_fd++;
`ifdef POOL_WINDOW_COUNT_EN
                exp_cnt++;
`endif
            end else begin
                check_val("frame_done_alone", 128'(frame_done), 128'(0));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_im"}, 128'(im), 128'(0));
        check_val({tag, "_mode"}, 128'(mode), 128'(0));
        check_val({tag, "_input_ready"}, 128'(input_ready), 128'(0));
        check_val({tag, "_frame_done"}, 128'(frame_done), 128'(0));
        check_val({tag, "_din_ready"}, 128'(din_ready), 128'(0));
`ifdef POOL_WINDOW_COUNT_EN
        check_val({tag, "_win_cnt"}, 128'(win_cnt), 128'(0));
`endif
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_val("din_ready_before_clk", 128'(din_ready), 128'(0));
        @(negedge clk);
        check_val("din_ready_after_clk", 128'(din_ready), 128'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, f0;

        // Power-on reset
        #23;
        check_reset_outputs("por");
        release_reset();

        // Sequential frame, pooling always idle
        pool_mode = 0;
        fill_seq(1);
        p0 = n_pulse; f0 = n_fd;
        send_frame(NPIX, 0, 2'b00, 2'b00, 0);
        drain();
        check_val("t1_pulses", 128'(n_pulse - p0), 128'(4));
        check_val("t1_frame_done", 128'(n_fd - f0), 128'(1));
        check_val("t1_mode", 128'(mode), 128'(0));

        // Pooling stage busy when the first window registers
        pool_mode = 2;
        pool_idle = 1'b0;
        fill_seq(1);
        fork
            send_frame(NPIX, 0, 2'b00, 2'b00, 0);
            begin
                int c = 0;
                @(negedge clk);
                while (din_ready && c < 100) begin
                    @(negedge clk);
                    c++;
                end
                check_val("stall_reached", 128'(din_ready), 128'(0));
                w1 = exp_q.size() != 0 ? exp_q[0].w : '0;
                repeat (20) begin
                    check_val("stall_im", 128'(im), 128'(w1));
                    check_val("stall_din_ready", 128'(din_ready), 128'(0));
                    check_val("stall_input_ready", 128'(input_ready), 128'(0));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                pool_idle = 1'b1;
                @(negedge clk);
                check_val("release_pulse", 128'(input_ready), 128'(1));
                @(negedge clk);
                check_val("release_din_ready", 128'(din_ready), 128'(1));
                pool_mode = 0;
            end
        join
        drain();

        // din_valid toggling every cycle
        fill_seq(1);
        p0 = n_pulse;
        send_frame(NPIX, 1, 2'b00, 2'b00, 0);
        drain();
        check_val("t3_pulses", 128'(n_pulse - p0), 128'(4));

        // Reset in the middle of a frame
        fill_seq(51);
        send_frame(6, 0, 2'b11, 2'b11, 0);
        check_val("mode_latched", 128'(mode), 128'(3));
        reset = 1'b0;
        exp_q.delete();
        gap = 100;
`ifdef POOL_WINDOW_COUNT_EN
        exp_cnt = 0;
`endif
        #2;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        release_reset();
        fill_seq(101);
        send_frame(NPIX, 0, 2'b00, 2'b00, 0);
        drain();

        // mode_in changes mid-frame are ignored until the next frame
        fill_seq(1);
        send_frame(NPIX, 0, 2'b01, 2'b10, 3);
        drain();
        send_frame(NPIX, 0, 2'b10, 2'b10, 0);
        drain();
        check_val("mode_next_frame", 128'(mode), 128'(2));

        // Randomised frames: data, valid gaps, pool_idle and mode changes
        pool_mode = 1;
        for (int f = 0; f < 6; f++) begin
            fill_rand();
            send_frame(NPIX, 2, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       int'($urandom_range(1, NPIX-1)));
            drain();
        end
        pool_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pool_window_gather.md
Name: pool_window_gather

Overview:
- Upstream feeder for the pooling stage.
- Accepts a row-major stream of IL.FL fixed-point activations from a feature map of ROW_W x ROW_H.
- Assembles non-overlapping 2x2 windows (stride 2) using a one-row line buffer.
- Presents each window as the 4-element im vector, with a one-cycle input_ready pulse and a per-frame mode, paced by the pooling stage's idle indication.

Parameters:
- IL, 4, integer bits of each data word.
- FL, 16, fractional bits of each data word.
- size, 4, elements per window. Fixed at 4 (2x2); any other value is illegal.
- ROW_W, 4, feature-map width in elements. Even, >=2.
- ROW_H, 4, feature-map height in rows. Even, >=2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- din  in  IL+FL  stream data word.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  block can accept din this cycle; transfer when din_valid&&din_ready.
- mode_in  in  2  pooling mode requested for the next frame.
- pool_idle  in  1  pooling stage is idle and its previous result has been taken.
- im  out  size x (IL+FL)  window: [0]=top-left, [1]=top-right, [2]=bottom-left, [3]=bottom-right.
- input_ready  out  1  one-cycle pulse: im/mode valid; pooling captures them.
- mode  out  2  mode latched for the current frame.
- frame_done  out  1  one-cycle pulse, coincident with input_ready of the last window in the frame.

Behaviour:
Reset (reset=0, asynchronous):
- im all zero, mode=0, input_ready=0, frame_done=0, din_ready=0.
- Counters (col, row), pending flag and guard counter cleared; state=IDLE.
- Line buffer contents are don't-care.
- din_ready goes 1 on the first clock after reset is released.
- Reset mid-frame discards the partial frame. The next accepted pixel is pixel (0,0) of a new frame.

States:
- IDLE:
  - First accepted pixel latches mode_in into mode and clears col/row.
  - That pixel is stored as line_buf[0] (col advances 0->1); go to TOP.
- TOP (even row):
  - Each accepted pixel writes line_buf[col]; col++.
  - At col==ROW_W-1, col wraps to 0 and row++; go to BOT.
- BOT (odd row):
  - Even col: pixel held in a left register.
  - Odd col: window registered into im on the accept edge: {line_buf[col-1], line_buf[col], left, din}; pending=1.
  - At the end of the row, col wraps to 0.
  - If row==ROW_H-1, mark the window as last, clear row and go to IDLE; otherwise row++ and go to TOP.

Flow control:
- din_ready = !pending. Conservative: input stalls whenever a window is waiting, in any state.
- Issue: when pending && pool_idle && guard==0, assert input_ready for exactly one cycle.
  - Same cycle: pending=0, guard=2.
  - frame_done=1 in the same cycle if the window is last.
- guard decrements each cycle while non-zero. This ensures no re-issue before pool_idle can reflect the new busy state.
- Latency: the earliest input_ready is the cycle after the bottom-right pixel is accepted.
- im and mode are held stable from window registration until the next window registers. Minimum spacing between pulses is 3 cycles.
- mode_in changes mid-frame are ignored until the next IDLE->TOP transition.
- Gaps in din_valid: no state change; counters hold.
- Simultaneous issue and din_valid: din_ready is computed from pending before the issue, so that pixel is not accepted that cycle.

Arithmetic:
- No arithmetic on data; words are passed bit-exact.
- col width $clog2(ROW_W); row width $clog2(ROW_H).

Optional Feature:
- Macro: POOL_WINDOW_COUNT_EN.
- Defined:
  - Adds output win_cnt, width $clog2(ROW_W*ROW_H/4+1).
  - Cleared on reset and on the IDLE->TOP transition.
  - Increments on each input_ready pulse; holds its value after frame_done until the next frame starts.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Stream 1..16 row-major, pool_idle=1, mode_in=00:
  - windows {1,2,5,6}, {3,4,7,8}, {9,10,13,14}, {11,12,15,16} in that order;
  - 4 input_ready pulses; frame_done with the 4th; mode=00 throughout.
- pool_idle=0 when window {1,2,5,6} registers:
  - din_ready=0, input_ready stays 0, im stable.
  - Raise pool_idle after 20 cycles: one pulse the next cycle, din_ready returns 1.
- din_valid toggled 1/0 each cycle with data 1..16: same windows and order as test 1; no duplicated or dropped pixels.
- Assert reset low after 6 accepted pixels:
  - im=0, mode=0, no pulse.
  - Then stream 101..116: first window {101,102,105,106}.
- mode_in=01 at first pixel, changed to 10 after pixel 3:
  - mode=01 for all 4 windows.
  - Next frame started with mode_in=10 gives mode=10.
- With POOL_WINDOW_COUNT_EN, test 1 stimulus: win_cnt steps 1,2,3,4, holds 4, and clears to 0 on the first pixel of the next frame.
